// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and defaults for the memory port arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant between fetch and data
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic take_i,
  output logic valid_o,
  output logic gnt_dm_o
);

  owner_e last_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    valid_o  = if_req_i | dm_req_i;
    gnt_dm_o = (if_req_i && dm_req_i) ? (last_q == OWN_IF) : dm_req_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= OWN_IF;
    end else if (take_i && valid_o) begin
      last_q <= gnt_dm_o ? OWN_DM : OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and data accesses onto one memory port
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              state_q;
  owner_e              owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_q, mem_we_q, if_done_q, dm_done_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, dm_rdata_q, resp_data;
  logic [DATA_W/8-1:0] mem_be_q;
  logic                gnt_valid, gnt_dm;

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .reset_i  (reset),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .take_i   (state_q == ST_IDLE),
    .valid_o  (gnt_valid),
    .gnt_dm_o (gnt_dm)
  );

  // Writes and timeouts return zero so stale read data never leaks out.
  always_comb begin
    resp_data = '0;
    if (mem_ack && !mem_we_q) resp_data = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q     <= gnt_dm ? OWN_DM : OWN_IF;
            mem_addr_q  <= gnt_dm ? dm_addr : if_addr;
            mem_we_q    <= gnt_dm & dm_we;
            mem_wdata_q <= gnt_dm ? dm_wdata : '0;
            mem_be_q    <= gnt_dm ? dm_be : '1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack || cnt_q == CNT_MAX) begin
            mem_req_q <= 1'b0;
            err_q     <= !mem_ack;
            state_q   <= ST_RESP;
            if (owner_q == OWN_DM) begin
              dm_done_q  <= 1'b1;
              dm_rdata_q <= resp_data;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= resp_data;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_be = '0;
  logic        if_done, dm_done, err, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_fail = 0, n_total = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from request to response; ack_on=0 means never ack.
  task automatic serve(input string tag, input logic exp_dm, input logic exp_we,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_be, input int ack_on,
                       input logic [31:0] rd, input int drop_at);
    int   busy;
    exp_t e;
    busy = 0;
    for (int i = 0; i < 4 && !mem_req; i++) cyc();
    chk({tag, "_mem_req_rise"}, mem_req, 1'b1);
    while (mem_req && busy < 3 * TO) begin
      busy++;
      chk({tag, "_mem_we"}, mem_we, exp_we);
      chk({tag, "_mem_addr"}, mem_addr, exp_addr);
      chk({tag, "_mem_be"}, mem_be, exp_be);
      if (exp_dm) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_no_done_busy"}, {if_done, dm_done}, 2'b00);
      if (busy == drop_at) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      if (busy == ack_on) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
        sb.push_back('{dm: exp_dm, rdata: (exp_we ? 32'h0 : rd), err: 1'b0});
      end else if (ack_on == 0 && busy == TO) begin
        mem_rdata = rd;
        sb.push_back('{dm: exp_dm, rdata: 32'h0, err: 1'b1});
      end
      cyc();
      mem_ack = 1'b0;
    end
    chk({tag, "_busy_cycles"}, busy, (ack_on == 0) ? TO : ack_on);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_if_done"}, if_done, !e.dm);
      chk({tag, "_dm_done"}, dm_done, e.dm);
      chk({tag, "_rdata"}, e.dm ? dm_rdata : if_rdata, e.rdata);
      chk({tag, "_err"}, err, e.err);
    end
    if (exp_dm) dm_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_dones", {if_done, dm_done}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_be}, '0);
    chk("rst_rdata", {if_rdata, dm_rdata}, '0);
    reset = 1'b0;
    cyc();
    chk("idle_no_req", mem_req, 1'b0);

    // Ties after reset: DM, IF, DM, IF.
    if_addr = 32'h40; dm_addr = 32'h800; dm_wdata = 32'hA5A5_0001; dm_be = 4'hF;
    if_req = 1'b1; dm_req = 1'b1;
    serve("tie1_dm", 1'b1, 1'b0, 32'h800, 32'hA5A5_0001, 4'hF, 1, 32'h1111_1111, 0);
    serve("tie2_if", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 2, 32'h2222_2222, 0);
    cyc();
    if_req = 1'b1; dm_req = 1'b1;
    serve("tie3_dm", 1'b1, 1'b0, 32'h800, 32'hA5A5_0001, 4'hF, 1, 32'h3333_3333, 0);
    serve("tie4_if", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 1, 32'h4444_4444, 0);
    cyc();

    // Single fetch, ack on first BUSY cycle.
    if_addr = 32'h100; if_req = 1'b1;
    cyc();
    chk("fetch_latency", mem_req, 1'b1);
    serve("fetch", 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 0);
    cyc();

    // Data write with 5-cycle ack delay.
    dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h1234_5678; dm_be = 4'b0011; dm_req = 1'b1;
    serve("write", 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 5, 32'hFFFF_FFFF, 0);
    cyc();

    // Timeout, then ack on the last allowed cycle.
    dm_we = 1'b0; dm_addr = 32'h2004; dm_req = 1'b1;
    serve("timeout", 1'b1, 1'b0, 32'h2004, 32'h1234_5678, 4'b0011, 0, 32'hCAFE_F00D, 0);
    cyc();
    if_addr = 32'h104; if_req = 1'b1;
    serve("late_ack", 1'b0, 1'b0, 32'h104, 32'h0, 4'hF, TO, 32'h0BAD_F00D, 0);
    cyc();

    // Reset asserted during the third BUSY cycle.
    dm_addr = 32'h3000; dm_req = 1'b1;
    for (int i = 0; i < 4 && !mem_req; i++) cyc();
    cyc(); cyc();
    chk("rst_mid_busy_before", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_async_drop", mem_req, 1'b0);
    dm_req = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_mid_no_done", {if_done, dm_done, mem_req}, 3'b000);
    end
    if_addr = 32'h200; if_req = 1'b1;
    serve("after_rst", 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 2, 32'h5555_AAAA, 0);
    cyc();

    // Request withdrawn mid-transaction still completes exactly once.
    dm_addr = 32'h4000; dm_wdata = 32'h0; dm_be = 4'hC; dm_req = 1'b1;
    serve("drop", 1'b1, 1'b0, 32'h4000, 32'h0, 4'hC, 3, 32'h7777_8888, 2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drop_no_phantom", {if_done, dm_done, mem_req}, 3'b000);
    end
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
